// File: rtl/piso_serializer.sv
// Framed parallel-in/serial-out transmitter: start bit, data MSB first, stop bit.
// Define PISO_PARITY_EN to insert an even-parity bit between the data and the stop bit.
module piso_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load,
    output logic             ready,
    output logic             so,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef PISO_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] sreg_reg, sreg_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic             so_reg, so_next;
    logic             done_reg, done_next;
    logic             busy_reg, busy_next;
    logic             accept;

`ifdef PISO_PARITY_EN
    logic par_reg, par_next;
`endif

    assign ready  = (state_reg == IDLE) || (state_reg == STOP);
    assign accept = load && ready;
    assign so     = so_reg;
    assign busy   = busy_reg;
    assign done   = done_reg;

    // so/done are computed for the state being entered, so they appear registered
    // in the same cycle the state does.
    always_comb begin
        state_next = state_reg;
        sreg_next  = sreg_reg;
        cnt_next   = cnt_reg;
        so_next    = 1'b0;
        done_next  = 1'b0;
`ifdef PISO_PARITY_EN
        par_next   = par_reg;
`endif
        case (state_reg)
            IDLE, STOP: begin
                if (accept) begin
                    state_next = START;
                    sreg_next  = din;
                    cnt_next   = '0;
                    so_next    = 1'b1;
`ifdef PISO_PARITY_EN
                    par_next   = ^din;
`endif
                end else begin
                    state_next = IDLE;
                end
            end
            START, DATA: begin
                // Counter holds at WIDTH once the last data bit is out.
                if (state_reg == DATA && cnt_reg == CW'(WIDTH)) begin
`ifdef PISO_PARITY_EN
                    state_next = PARITY;
                    so_next    = par_reg;
`else
                    state_next = STOP;
                    done_next  = 1'b1;
`endif
                end else begin
                    state_next = DATA;
                    so_next    = sreg_reg[WIDTH-1];
                    sreg_next  = {sreg_reg[WIDTH-2:0], 1'b0};
                    cnt_next   = cnt_reg + CW'(1);
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_next = STOP;
                done_next  = 1'b1;
            end
`endif
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sreg_reg  <= '0;
            cnt_reg   <= '0;
            so_reg    <= 1'b0;
            done_reg  <= 1'b0;
            busy_reg  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            sreg_reg  <= sreg_next;
            cnt_reg   <= cnt_next;
            so_reg    <= so_next;
            done_reg  <= done_next;
            busy_reg  <= busy_next;
`ifdef PISO_PARITY_EN
            par_reg   <= par_next;
`endif
        end
    end

endmodule
